// File: rtl/mult_reg_sequencer.sv
// mult_reg_sequencer: sequences Thumb PUSH/POP/STMIA/LDMIA one register per beat,
// then performs a single base-register writeback cycle.
// Optional feature macro: MULT_REG_LR_PC_EN (adds LR to PUSH / PC to POP via instr_i[8]).
module mult_reg_sequencer #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [15:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] base_val_i,
  input  logic                  mem_ready_i,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o,
  output logic                  reg_wr_en_o,
  output logic                  pc_load_o,
  output logic [ADDR_WIDTH-1:0] base_addr_o,
  output logic                  base_wb_en_o,
  output logic [DATA_WIDTH-1:0] base_wb_val_o,
  output logic                  done_o
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] SP_IDX = ADDR_WIDTH'(13);
`ifdef MULT_REG_LR_PC_EN
  localparam logic [ADDR_WIDTH-1:0] LR_IDX = ADDR_WIDTH'(14);
  localparam logic [ADDR_WIDTH-1:0] PC_IDX = ADDR_WIDTH'(15);
`endif

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  state_t                state;
  logic [NUM_REGS-1:0]   mask;
  logic                  wb_en_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0] wb_val_q;
`ifdef MULT_REG_LR_PC_EN
  logic                  is_pop_q;
  logic                  pc_load_q;
  logic                  next_pc;
`endif

  logic                  op_push, op_pop, op_stm, op_ldm, accept;
  logic [ADDR_WIDTH-1:0] acc_rn, acc_base;
  logic [NUM_REGS-1:0]   acc_mask, rest_mask, next_mask;
  logic [DATA_WIDTH-1:0] acc_bytes, acc_addr, acc_wb_val;
  logic                  acc_wb_en;
  logic [ADDR_WIDTH-1:0] next_idx;

  function automatic logic [DATA_WIDTH-1:0] popcount(input logic [NUM_REGS-1:0] m);
    popcount = '0;
    for (int i = 0; i < NUM_REGS; i++) popcount = popcount + DATA_WIDTH'(m[i]);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] lowest(input logic [NUM_REGS-1:0] m);
    lowest = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) if (m[i]) lowest = ADDR_WIDTH'(i);
  endfunction

  // Decode the candidate instruction and precompute everything latched at accept
  always_comb begin
    op_push   = (instr_i[15:9] == 7'b1011010);
    op_pop    = (instr_i[15:9] == 7'b1011110);
    op_stm    = (instr_i[15:11] == 5'b11000);
    op_ldm    = (instr_i[15:11] == 5'b11001);
    accept    = (state == IDLE) && start_i && (op_push || op_pop || op_stm || op_ldm);
    acc_rn    = ADDR_WIDTH'(instr_i[10:8]);
    acc_mask  = NUM_REGS'(instr_i[7:0]);
`ifdef MULT_REG_LR_PC_EN
    if (op_push && instr_i[8]) acc_mask[LR_IDX] = 1'b1;
    if (op_pop && instr_i[8])  acc_mask[PC_IDX] = 1'b1;
`endif
    acc_bytes  = popcount(acc_mask) << 2;
    acc_addr   = op_push ? (base_val_i - acc_bytes) : base_val_i;
    acc_wb_val = op_push ? (base_val_i - acc_bytes) : (base_val_i + acc_bytes);
    acc_wb_en  = !(op_ldm && acc_mask[acc_rn]);
    acc_base   = (op_push || op_pop) ? SP_IDX : acc_rn;
  end

  // Select the register for the next beat: from the fresh list at accept, else the remainder
  always_comb begin
    rest_mask             = mask;
    rest_mask[reg_addr_o] = 1'b0;
    next_mask             = (state == IDLE) ? acc_mask : rest_mask;
    next_idx              = lowest(next_mask);
`ifdef MULT_REG_LR_PC_EN
    next_pc               = ((state == IDLE) ? op_pop : is_pop_q) && (next_idx == PC_IDX);
`endif
  end

  assign busy_o      = (state != IDLE) || accept;
  assign reg_wr_en_o = mem_rd_en_o && mem_ready_i;
`ifdef MULT_REG_LR_PC_EN
  assign pc_load_o   = pc_load_q;
`else
  assign pc_load_o   = 1'b0;
`endif

  // Sequencer FSM with registered beat and writeback outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      mask          <= '0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_val_q      <= '0;
      reg_addr_o    <= '0;
      mem_addr_o    <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      base_addr_o   <= '0;
      base_wb_en_o  <= 1'b0;
      base_wb_val_o <= '0;
      done_o        <= 1'b0;
`ifdef MULT_REG_LR_PC_EN
      is_pop_q      <= 1'b0;
      pc_load_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mask      <= acc_mask;
            wb_en_q   <= acc_wb_en;
            wb_addr_q <= acc_base;
            wb_val_q  <= acc_wb_val;
`ifdef MULT_REG_LR_PC_EN
            is_pop_q  <= op_pop;
`endif
            if (acc_mask != '0) begin
              state       <= XFER;
              reg_addr_o  <= next_idx;
              mem_addr_o  <= acc_addr;
              mem_wr_en_o <= op_push || op_stm;
              mem_rd_en_o <= op_pop || op_ldm;
`ifdef MULT_REG_LR_PC_EN
              pc_load_q   <= next_pc;
`endif
            end else begin
              state         <= WB;
              base_addr_o   <= acc_base;
              base_wb_en_o  <= acc_wb_en;
              base_wb_val_o <= acc_wb_val;
              done_o        <= 1'b1;
            end
          end
        end
        XFER: begin
          if (mem_ready_i) begin
            mask <= rest_mask;
            if (rest_mask != '0) begin
              reg_addr_o <= next_idx;
              mem_addr_o <= mem_addr_o + DATA_WIDTH'(4);
`ifdef MULT_REG_LR_PC_EN
              pc_load_q  <= next_pc;
`endif
            end else begin
              state         <= WB;
              reg_addr_o    <= '0;
              mem_addr_o    <= '0;
              mem_wr_en_o   <= 1'b0;
              mem_rd_en_o   <= 1'b0;
              base_addr_o   <= wb_addr_q;
              base_wb_en_o  <= wb_en_q;
              base_wb_val_o <= wb_val_q;
              done_o        <= 1'b1;
`ifdef MULT_REG_LR_PC_EN
              pc_load_q     <= 1'b0;
`endif
            end
          end
        end
        WB: begin
          state         <= IDLE;
          base_addr_o   <= '0;
          base_wb_en_o  <= 1'b0;
          base_wb_val_o <= '0;
          done_o        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_reg_sequencer.sv
// Directed self-checking bench for mult_reg_sequencer.
module tb_mult_reg_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] instr_i;
  logic [31:0] base_val_i;
  logic        mem_ready_i;
  logic        busy_o;
  logic [3:0]  reg_addr_o;
  logic [31:0] mem_addr_o;
  logic        mem_wr_en_o;
  logic        mem_rd_en_o;
  logic        reg_wr_en_o;
  logic        pc_load_o;
  logic [3:0]  base_addr_o;
  logic        base_wb_en_o;
  logic [31:0] base_wb_val_o;
  logic        done_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  mult_reg_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .instr_i(instr_i),
    .base_val_i(base_val_i), .mem_ready_i(mem_ready_i), .busy_o(busy_o),
    .reg_addr_o(reg_addr_o), .mem_addr_o(mem_addr_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_rd_en_o(mem_rd_en_o), .reg_wr_en_o(reg_wr_en_o), .pc_load_o(pc_load_o),
    .base_addr_o(base_addr_o), .base_wb_en_o(base_wb_en_o),
    .base_wb_val_o(base_wb_val_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Beat presentation: register, address, store/load enables
  task automatic chk_beat(input string tag, input logic [3:0] r, input logic [31:0] a,
                          input logic wr, input logic rd);
    chk({tag, ".reg"}, 32'(reg_addr_o), 32'(r));
    chk({tag, ".addr"}, mem_addr_o, a);
    chk({tag, ".wr"}, 32'(mem_wr_en_o), 32'(wr));
    chk({tag, ".rd"}, 32'(mem_rd_en_o), 32'(rd));
  endtask

  // Writeback cycle: done pulse, base register, enable and value
  task automatic chk_wb(input string tag, input logic [3:0] ba, input logic en,
                        input logic [31:0] v);
    chk({tag, ".done"}, 32'(done_o), 32'd1);
    chk({tag, ".base_addr"}, 32'(base_addr_o), 32'(ba));
    chk({tag, ".wb_en"}, 32'(base_wb_en_o), 32'(en));
    if (en) chk({tag, ".wb_val"}, base_wb_val_o, v);
    chk({tag, ".mem_en"}, 32'(mem_wr_en_o | mem_rd_en_o), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"}, 32'(busy_o), 32'd0);
    chk({tag, ".outs"}, {reg_addr_o, base_addr_o, 20'd0, mem_wr_en_o, mem_rd_en_o,
                         reg_wr_en_o, pc_load_o, base_wb_en_o, done_o, 2'b00}, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, ".wb_val"}, base_wb_val_o, 32'd0);
  endtask

  task automatic start(input logic [15:0] ins, input logic [31:0] base);
    start_i    = 1'b1;
    instr_i    = ins;
    base_val_i = base;
    #1;
    chk("accept.busy_comb", 32'(busy_o), 32'd1);
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; instr_i = 16'h0; base_val_i = 32'h0; mem_ready_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    chk_quiet("reset");

    // PUSH {R0,R2}, SP=0x1000
    start(16'hB405, 32'h0000_1000);
    chk_beat("push.b0", 4'd0, 32'h0000_0FF8, 1'b1, 1'b0);
    tick();
    chk_beat("push.b1", 4'd2, 32'h0000_0FFC, 1'b1, 1'b0);
    tick();
    chk_wb("push.wb", 4'd13, 1'b1, 32'h0000_0FF8);
    tick();
    chk_quiet("push.idle");

    // LDMIA R1!,{R1,R3}: base in list suppresses writeback
    start(16'hC90A, 32'h0000_2000);
    chk_beat("ldm.b0", 4'd1, 32'h0000_2000, 1'b0, 1'b1);
    chk("ldm.b0.regwr", 32'(reg_wr_en_o), 32'd1);
    tick();
    chk_beat("ldm.b1", 4'd3, 32'h0000_2004, 1'b0, 1'b1);
    chk("ldm.b1.regwr", 32'(reg_wr_en_o), 32'd1);
    tick();
    chk_wb("ldm.wb", 4'd1, 1'b0, 32'h0);
    tick();

    // STMIA R0!,{R4} with three stalled cycles
    mem_ready_i = 1'b0;
    start(16'hC010, 32'h0000_3000);
    for (int i = 0; i < 3; i++) begin
      chk_beat("stm.hold", 4'd4, 32'h0000_3000, 1'b1, 1'b0);
      chk("stm.hold.busy", 32'(busy_o), 32'd1);
      tick();
    end
    mem_ready_i = 1'b1;
    chk_beat("stm.go", 4'd4, 32'h0000_3000, 1'b1, 1'b0);
    chk("stm.go.regwr", 32'(reg_wr_en_o), 32'd0);
    tick();
    chk_wb("stm.wb", 4'd0, 1'b1, 32'h0000_3004);
    chk("stm.wb.busy", 32'(busy_o), 32'd1);
    tick();

    // POP {R7,PC}: PC beat only with the feature enabled
    start(16'hBD80, 32'h0000_1FF8);
    chk_beat("pop.b0", 4'd7, 32'h0000_1FF8, 1'b0, 1'b1);
    chk("pop.b0.pc", 32'(pc_load_o), 32'd0);
    tick();
`ifdef MULT_REG_LR_PC_EN
    chk_beat("pop.pc", 4'd15, 32'h0000_1FFC, 1'b0, 1'b1);
    chk("pop.pc.load", 32'(pc_load_o), 32'd1);
    tick();
    chk_wb("pop.wb", 4'd13, 1'b1, 32'h0000_2000);
`else
    chk_wb("pop.wb", 4'd13, 1'b1, 32'h0000_1FFC);
`endif
    chk("pop.wb.pc", 32'(pc_load_o), 32'd0);
    tick();

    // Empty STMIA R2!,{} and a start during WB that must be ignored
    start(16'hC200, 32'h0000_4000);
    chk_wb("empty.wb", 4'd2, 1'b1, 32'h0000_4000);
    start_i = 1'b1; instr_i = 16'hB405; base_val_i = 32'h0000_5000;
    tick();
    start_i = 1'b0;
    #1;
    chk_quiet("empty.ignored");
    tick();
    chk_quiet("empty.ignored2");

    // PUSH {R0} from SP=0 wraps silently
    start(16'hB401, 32'h0000_0000);
    chk_beat("wrap.b0", 4'd0, 32'hFFFF_FFFC, 1'b1, 1'b0);
    tick();
    chk_wb("wrap.wb", 4'd13, 1'b1, 32'hFFFF_FFFC);
    tick();

    // Non-matching encoding is ignored
    start_i = 1'b1; instr_i = 16'h1234;
    #1;
    chk("bad.busy", 32'(busy_o), 32'd0);
    tick();
    start_i = 1'b0;
    chk_quiet("bad.idle");

    // Reset mid-transfer of PUSH {R0,R1,R2}
    start(16'hB407, 32'h0000_1000);
    chk_beat("rst.b0", 4'd0, 32'h0000_0FF4, 1'b1, 1'b0);
    rst_i = 1'b1;
    tick();
    chk_quiet("rst.c1");
    tick();
    chk_quiet("rst.c2");
    rst_i = 1'b0;
    tick();
    chk_quiet("rst.after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
